// File: rtl/addsub_pipe_nbit_if.sv
// addsub_pipe_nbit_if: valid/ready stream bundle for the pipelined add/sub.
//   in_valid/in_ready/x/y/add_n/sat    request stream (producer -> block)
//   out_valid/out_ready/s/cout/ovf/zero result stream (block -> consumer)
//   slave modport is the block side, master modport is the producer/consumer side.
interface addsub_pipe_nbit_if #(parameter int n = 8) ();
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] x;
    logic [n-1:0] y;
    logic         add_n;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    modport slave (
        input  in_valid, x, y, add_n, sat, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
    modport master (
        output in_valid, x, y, add_n, sat, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_pipe_nbit.sv
// addsub_pipe_nbit: pipelined n-bit adder/subtractor, carry chain split into `stages` slices.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every valid/data/flag register
//   bus    slave side of addsub_pipe_nbit_if: request x/y/add_n/sat, result s/cout/ovf/zero
// All stages advance together on en = !out_valid | out_ready; latency is `stages` cycles.
module addsub_pipe_nbit #(
    parameter int n      = 8,
    parameter int stages = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_pipe_nbit_if.slave bus
);
    localparam int W = n / stages;

    if (n < 2 || stages < 1 || n % stages != 0) begin : g_bad
        $error("addsub_pipe_nbit: n must be >= 2 and a multiple of stages");
    end

    logic         en;
    logic         o_valid;
    logic         o_cout;
    logic         o_ovf;
    logic         o_zero;
    logic [n-1:0] o_s;

    assign en            = !o_valid || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = o_valid;
    assign bus.s         = o_s;
    assign bus.cout      = o_cout;
    assign bus.ovf       = o_ovf;
    assign bus.zero      = o_zero;

    // Stage k owns operand bits [n-1:k*W] (the not-yet-added upper slices, already
    // skewed) and the finished sum bits [k*W-1:0] (deskewed lower slices).
    for (genvar k = 0; k < stages; k++) begin : g_st
        localparam int R = n - k * W;
        logic [R-1:0]         xin;
        logic [R-1:0]         yin;
        logic [(k+1)*W-1:0]   acc;
        logic                 ci;
        logic                 vi;
        logic                 ti;
        logic [W:0]           sum;

        if (k == 0) begin : g_in
            // Subtraction: invert y once here; carry-in of 1 completes the two's complement.
            assign xin = bus.x;
            assign yin = bus.y ^ {n{bus.add_n}};
            assign ci  = bus.add_n;
            assign vi  = bus.in_valid;
            assign ti  = bus.sat;
            assign acc = sum[W-1:0];
        end else begin : g_in
            assign xin = g_st[k-1].g_r.xq;
            assign yin = g_st[k-1].g_r.yq;
            assign ci  = g_st[k-1].g_r.cq;
            assign vi  = g_st[k-1].g_r.vq;
            assign ti  = g_st[k-1].g_r.tq;
            assign acc = {sum[W-1:0], g_st[k-1].g_r.sq};
        end

        assign sum = {1'b0, xin[W-1:0]} + {1'b0, yin[W-1:0]} + {{W{1'b0}}, ci};

        if (k < stages - 1) begin : g_r
            logic [R-W-1:0]     xq;
            logic [R-W-1:0]     yq;
            logic [(k+1)*W-1:0] sq;
            logic               vq;
            logic               cq;
            logic               tq;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xq <= '0;
                    yq <= '0;
                    sq <= '0;
                    vq <= 1'b0;
                    cq <= 1'b0;
                    tq <= 1'b0;
                end else if (en) begin
                    xq <= xin[R-1:W];
                    yq <= yin[R-1:W];
                    sq <= acc;
                    vq <= vi;
                    cq <= sum[W];
                    tq <= ti;
                end
            end
        end else begin : g_o
            logic         c_msb;
            logic         v_raw;
            logic [n-1:0] res;
            // Carry into the MSB recovered from the MSB sum bit; the MSB slice always
            // lives in this last stage, so xin[W-1] is the delayed x[n-1].
            assign c_msb = xin[W-1] ^ yin[W-1] ^ acc[n-1];
            assign v_raw = c_msb ^ sum[W];
            assign res   = (ti && v_raw) ? {xin[W-1], {(n-1){!xin[W-1]}}} : acc;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_valid <= 1'b0;
                    o_s     <= '0;
                    o_cout  <= 1'b0;
                    o_ovf   <= 1'b0;
                    o_zero  <= 1'b0;
                end else if (en) begin
                    o_valid <= vi;
                    o_s     <= res;
                    o_cout  <= sum[W];
                    o_ovf   <= v_raw;
                    o_zero  <= (res == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// tb_addsub_pipe_nbit: drives three configurations (8/2, 8/1, 16/4) in lockstep and
// scoreboards each one's results, latency, stall stability and in_ready.
module tb_addsub_pipe_nbit;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       a;
        logic       t;
        logic [7:0] s;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_d = 1'b0;
    logic        add_n_d = 1'b0;
    logic        sat_d = 1'b0;
    logic        out_ready_d = 1'b1;
    logic [15:0] x_d = '0;
    logic [15:0] y_d = '0;
    logic        fire;
    logic        lat_chk = 1'b0;
    logic        rnd_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat [3] = '{2, 1, 4};
    exp_t        cur_e [3];
    exp_t        sb [3][$];
    logic        held [3];
    exp_t        hv [3];
    logic        act_v [3];
    logic        act_ir [3];
    logic        act_c [3];
    logic        act_o [3];
    logic        act_z [3];
    logic [15:0] act_s [3];
    vec_t        tbl [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_pipe_nbit_if #(.n(8))  b0 ();
    addsub_pipe_nbit_if #(.n(8))  b1 ();
    addsub_pipe_nbit_if #(.n(16)) b2 ();

    addsub_pipe_nbit #(.n(8),  .stages(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    addsub_pipe_nbit #(.n(8),  .stages(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    addsub_pipe_nbit #(.n(16), .stages(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    // A request is offered to all three only when all three can take it, keeping them in step.
    assign fire = in_valid_d & b0.in_ready & b1.in_ready & b2.in_ready;

    assign b0.in_valid = fire;
    assign b0.x = x_d[7:0];
    assign b0.y = y_d[7:0];
    assign b0.add_n = add_n_d;
    assign b0.sat = sat_d;
    assign b0.out_ready = out_ready_d;
    assign b1.in_valid = fire;
    assign b1.x = x_d[7:0];
    assign b1.y = y_d[7:0];
    assign b1.add_n = add_n_d;
    assign b1.sat = sat_d;
    assign b1.out_ready = out_ready_d;
    assign b2.in_valid = fire;
    assign b2.x = x_d;
    assign b2.y = y_d;
    assign b2.add_n = add_n_d;
    assign b2.sat = sat_d;
    assign b2.out_ready = out_ready_d;

    assign act_v[0] = b0.out_valid;
    assign act_ir[0] = b0.in_ready;
    assign act_s[0] = {8'h00, b0.s};
    assign act_c[0] = b0.cout;
    assign act_o[0] = b0.ovf;
    assign act_z[0] = b0.zero;
    assign act_v[1] = b1.out_valid;
    assign act_ir[1] = b1.in_ready;
    assign act_s[1] = {8'h00, b1.s};
    assign act_c[1] = b1.cout;
    assign act_o[1] = b1.ovf;
    assign act_z[1] = b1.zero;
    assign act_v[2] = b2.out_valid;
    assign act_ir[2] = b2.in_ready;
    assign act_s[2] = b2.s;
    assign act_c[2] = b2.cout;
    assign act_o[2] = b2.ovf;
    assign act_z[2] = b2.zero;

    // Reference: signed overflow from operand/result sign bits, not from carries.
    function automatic exp_t model(input int nb, input logic [15:0] xv, input logic [15:0] yv,
                                   input logic a, input logic t);
        exp_t        e;
        logic [16:0] m;
        logic [16:0] full;
        logic [15:0] yi;
        logic        xs;
        logic        ys;
        logic        rs;
        m = (17'd1 << nb) - 17'd1;
        yi = a ? ~yv : yv;
        full = ({1'b0, xv} & m) + ({1'b0, yi} & m) + 17'(a);
        xs = xv[nb-1];
        ys = yi[nb-1];
        rs = full[nb-1];
        e.c = full[nb];
        e.o = (xs == ys) && (rs != xs);
        e.s = full[15:0] & m[15:0];
        if (t && e.o) e.s = xs ? (m[15:0] >> 1) + 16'd1 : m[15:0] >> 1;
        e.z = (e.s == 16'd0);
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (act_ir[d] !== (!act_v[d] || out_ready_d)) begin
                errors++;
                $display("FAIL in_ready dut%0d: got %b expected %b", d, act_ir[d], !act_v[d] || out_ready_d);
            end
            if (fire) begin
                e = cur_e[d];
                e.cyc = cyc;
                sb[d].push_back(e);
            end
            if (held[d]) begin
                checks++;
                if ({act_v[d], act_s[d], act_c[d], act_o[d], act_z[d]} !== {1'b1, hv[d].s, hv[d].c, hv[d].o, hv[d].z}) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: got v=%b s=%h c=%b o=%b z=%b expected v=1 s=%h c=%b o=%b z=%b",
                             d, act_v[d], act_s[d], act_c[d], act_o[d], act_z[d], hv[d].s, hv[d].c, hv[d].o, hv[d].z);
                end
            end
            if (act_v[d] && out_ready_d) begin
                checks++;
                if (sb[d].size() == 0) begin
                    errors++;
                    $display("FAIL extra_output dut%0d: got s=%h with nothing expected", d, act_s[d]);
                end else begin
                    e = sb[d].pop_front();
                    if ({act_s[d], act_c[d], act_o[d], act_z[d]} !== {e.s, e.c, e.o, e.z}) begin
                        errors++;
                        $display("FAIL result dut%0d: got s=%h c=%b o=%b z=%b expected s=%h c=%b o=%b z=%b",
                                 d, act_s[d], act_c[d], act_o[d], act_z[d], e.s, e.c, e.o, e.z);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - e.cyc != lat[d]) begin
                            errors++;
                            $display("FAIL latency dut%0d: got %0d expected %0d", d, cyc - e.cyc, lat[d]);
                        end
                    end
                end
            end
            held[d] = act_v[d] && !out_ready_d;
            hv[d] = '{act_s[d], act_c[d], act_o[d], act_z[d], 0};
        end
    end

    task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic a, input logic t,
                        input exp_t e8);
        logic ok;
        ok = 1'b0;
        x_d = xv;
        y_d = yv;
        add_n_d = a;
        sat_d = t;
        cur_e[0] = e8;
        cur_e[1] = e8;
        cur_e[2] = model(16, xv, yv, a, t);
        in_valid_d = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = fire;
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready_d = 1'($urandom_range(0, 1));
        end
        in_valid_d = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got no input transfer expected one within 200 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready_d = 1'b1;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0", sb[0].size(), sb[1].size(), sb[2].size());
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({act_v[d], act_s[d], act_c[d], act_o[d], act_z[d]} !== 20'd0) begin
                errors++;
                $display("FAIL %s dut%0d: got v=%b s=%h c=%b o=%b z=%b expected all 0",
                         tag, d, act_v[d], act_s[d], act_c[d], act_o[d], act_z[d]);
            end
        end
    endtask

    initial begin
        exp_t e8;
        logic [15:0] rx;
        logic [15:0] ry;
        logic ra;
        logic rt;
        tbl[0] = '{8'h3A, 8'h05, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h10, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{8'h05, 8'h3A, 1'b1, 1'b0, 8'hCB, 1'b0, 1'b0, 1'b0};
        for (int d = 0; d < 3; d++) held[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e8 = '{{8'h00, tbl[i].s}, tbl[i].c, tbl[i].o, tbl[i].z, 0};
            send({8'h00, tbl[i].x}, {8'h00, tbl[i].y}, tbl[i].a, tbl[i].t, e8);
            drain();
        end
        lat_chk = 1'b0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            ra = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 1));
            send(rx, ry, ra, rt, model(8, rx, ry, ra, rt));
        end
        rnd_mode = 1'b0;
        drain();
        lat_chk = 1'b1;
        send(16'h0011, 16'h0022, 1'b0, 1'b0, model(8, 16'h0011, 16'h0022, 1'b0, 1'b0));
        send(16'h0040, 16'h0050, 1'b0, 1'b1, model(8, 16'h0040, 16'h0050, 1'b0, 1'b1));
        rst_n = 1'b0;
        #1;
        chk_reset("reset_inflight");
        for (int d = 0; d < 3; d++) begin
            sb[d].delete();
            held[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send({8'h00, tbl[0].x}, {8'h00, tbl[0].y}, 1'b0, 1'b0, '{16'h003F, 1'b0, 1'b0, 1'b0, 0});
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
